// File: rtl/tama_event_arbiter.sv
// -----------------------------------------------------------------------------
// tama_event_arbiter
//
// Serializes the four debounced pet stimulus sources (heal, feed, play,
// energy) into one event stream for tamagotchi_fsm. Each request pulse is
// latched as a pending flag. One event at a time is presented with a
// valid/ack handshake. A grant only starts while the LCD controller reports
// idle. After every completed or timed-out grant, a cooldown period runs
// before the next grant can start.
//
// Configuration macro:
//   TAMA_ARB_FIXED_PRIO_EN  defined   -> fixed priority, heal (bit0) highest
//                           undefined -> round-robin (default)
//
// Parameters:
//   COOLDOWN     idle cycles after each grant ends (>= 1)
//   ACK_TIMEOUT  cycles evt_valid waits for evt_ack before the event is dropped (>= 1)
//   CNT_W        width of the shared cooldown/timeout counter
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-low reset
//   req[3:0]     single-cycle request pulses (0 heal, 1 feed, 2 play, 3 energy)
//   lcd_ready_i  LCD controller idle; grants start only while high
//   evt_ack      consumer accepts the presented event
//   evt_valid    event presented
//   evt_id[1:0]  index of the presented event, stable while evt_valid
//   pending[3:0] latched requests that have not been granted yet
//   timeout_o    one-cycle pulse when a grant is dropped on timeout
//   drop_cnt     saturating count of requests that arrived while already pending
// -----------------------------------------------------------------------------
module tama_event_arbiter #(
    parameter int COOLDOWN    = 25_000_000,
    parameter int ACK_TIMEOUT = 1_000_000,
    parameter int CNT_W       = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       lcd_ready_i,
    input  logic       evt_ack,
    output logic       evt_valid,
    output logic [1:0] evt_id,
    output logic [3:0] pending,
    output logic       timeout_o,
    output logic [7:0] drop_cnt
);

    localparam logic [CNT_W-1:0] ACK_LOAD  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_COOL  = 2'd2
    } state_t;

    state_t           state_q;
    logic             evt_valid_q;
    logic [1:0]       evt_id_q;
    logic [3:0]       pending_q;
    logic             timeout_q;
    logic [7:0]       drop_cnt_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       rr_ptr;

`ifdef TAMA_ARB_FIXED_PRIO_EN
    // Fixed priority: the scan always starts at heal (bit0).
    assign rr_ptr = 2'd0;
`else
    logic [1:0] rr_ptr_q;
    assign rr_ptr = rr_ptr_q;
`endif

    // The current grant finishes this cycle, either accepted or timed out.
    logic grant_done;
    assign grant_done = (state_q == ST_GRANT) && (evt_ack || (cnt_q == '0));

    logic [3:0] clear_vec;
    logic [3:0] drop_vec;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bit
            assign clear_vec[gi] = grant_done && (evt_id_q == 2'(gi));
            // A request for a flag being cleared this cycle re-arms it instead
            // of counting as a drop.
            assign drop_vec[gi]  = req[gi] && pending_q[gi] && !clear_vec[gi];
        end
    endgenerate

    logic [3:0] pending_d;
    assign pending_d = (pending_q & ~clear_vec) | req;

    // Saturating drop counter: several drops in one cycle add together.
    logic [2:0] drop_sum;
    logic [8:0] drop_total;
    logic [7:0] drop_cnt_d;
    assign drop_sum   = {2'b00, drop_vec[0]} + {2'b00, drop_vec[1]}
                      + {2'b00, drop_vec[2]} + {2'b00, drop_vec[3]};
    assign drop_total = {1'b0, drop_cnt_q} + {6'b000000, drop_sum};
    assign drop_cnt_d = drop_total[8] ? 8'hFF : drop_total[7:0];

    // Round-robin winner: rotate pending so the pointer lands at bit0, take
    // the lowest set bit, then rotate the offset back.
    logic [7:0] pend_dbl;
    logic [3:0] pend_rot;
    logic [1:0] win_off;
    logic [1:0] win_id;
    assign pend_dbl = {pending_q, pending_q};
    assign pend_rot = pend_dbl[rr_ptr +: 4];

    always_comb begin
        win_off = 2'd3;
        if (pend_rot[0]) begin
            win_off = 2'd0;
        end else if (pend_rot[1]) begin
            win_off = 2'd1;
        end else if (pend_rot[2]) begin
            win_off = 2'd2;
        end
    end

    assign win_id = rr_ptr + win_off;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            evt_valid_q <= 1'b0;
            evt_id_q    <= 2'd0;
            pending_q   <= 4'd0;
            timeout_q   <= 1'b0;
            drop_cnt_q  <= 8'd0;
            cnt_q       <= '0;
`ifndef TAMA_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= 2'd0;
`endif
        end else begin
            pending_q  <= pending_d;
            drop_cnt_q <= drop_cnt_d;
            timeout_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if ((pending_q != 4'd0) && lcd_ready_i) begin
                        evt_id_q    <= win_id;
                        evt_valid_q <= 1'b1;
                        cnt_q       <= ACK_LOAD;
                        state_q     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (grant_done) begin
                        evt_valid_q <= 1'b0;
                        cnt_q       <= COOL_LOAD;
                        state_q     <= ST_COOL;
                        // An ack on the final cycle still counts as accepted.
                        timeout_q   <= !evt_ack;
`ifndef TAMA_ARB_FIXED_PRIO_EN
                        rr_ptr_q    <= evt_id_q + 2'd1;
`endif
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_COOL: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign pending   = pending_q;
    assign timeout_o = timeout_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_tama_event_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for tama_event_arbiter (COOLDOWN=4, ACK_TIMEOUT=6).
// A timestamp-based reference model predicts every output on every cycle.
// Directed scenarios add literal expectations, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_tama_event_arbiter;

    localparam int COOLDOWN    = 4;
    localparam int ACK_TIMEOUT = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'd0;
    logic       lcd_ready_i = 1'b0;
    logic       evt_ack = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic [3:0] pending;
    logic       timeout_o;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    tama_event_arbiter #(
        .COOLDOWN   (COOLDOWN),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .CNT_W      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .lcd_ready_i(lcd_ready_i),
        .evt_ack    (evt_ack),
        .evt_valid  (evt_valid),
        .evt_id     (evt_id),
        .pending    (pending),
        .timeout_o  (timeout_o),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Time-stamped view: a grant may start at edge n only if no event is
    // shown and n >= (edge the last grant ended) + COOLDOWN + 1. A grant
    // ends on ack, or when ACK_TIMEOUT edges have passed since it began.
    bit [3:0] m_pend  = 4'd0;
    int       m_drop  = 0;
    bit       m_valid = 1'b0;
    bit [1:0] m_id    = 2'd0;
    bit       m_to    = 1'b0;
    int       m_rr    = 0;
    longint   m_n     = 0;
    longint   m_last_end = -1000;
    longint   m_grant_edge = 0;
    bit [3:0] m_old;
    bit [3:0] m_clr;
    bit       m_found;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend = 4'd0; m_drop = 0; m_valid = 1'b0; m_id = 2'd0; m_to = 1'b0;
            m_rr = 0; m_n = 0; m_last_end = -1000; m_grant_edge = 0;
        end else begin
            m_n   = m_n + 1;
            m_old = m_pend;
            m_clr = 4'd0;
            m_to  = 1'b0;
            if (m_valid) begin
                if (evt_ack || (m_n - m_grant_edge == ACK_TIMEOUT)) begin
                    m_to = !evt_ack;
                    m_clr[m_id] = 1'b1;
                    m_valid = 1'b0;
                    m_last_end = m_n;
`ifndef TAMA_ARB_FIXED_PRIO_EN
                    m_rr = (int'(m_id) + 1) % 4;
`endif
                end
            end else if (m_old != 4'd0 && lcd_ready_i && m_n >= m_last_end + COOLDOWN + 1) begin
                m_found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if (!m_found && m_old[(m_rr + k) % 4]) begin
                        m_id = 2'((m_rr + k) % 4);
                        m_found = 1'b1;
                    end
                end
                m_valid = 1'b1;
                m_grant_edge = m_n;
            end
            for (int i = 0; i < 4; i++) begin
                if (req[i] && m_old[i] && !m_clr[i] && m_drop < 255) m_drop = m_drop + 1;
            end
            m_pend = (m_old & ~m_clr) | req;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (evt_valid !== m_valid || pending !== m_pend || timeout_o !== m_to ||
                drop_cnt !== 8'(m_drop) || (m_valid && evt_id !== m_id)) begin
                n_err++;
                $display("FAIL cycle_cmp t=%0t: dut v=%b id=%0d pend=%b to=%b drop=%0d, model v=%b id=%0d pend=%b to=%b drop=%0d",
                         $time, evt_valid, evt_id, pending, timeout_o, drop_cnt,
                         m_valid, m_id, m_pend, m_to, m_drop);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; req = 4'd0; evt_ack = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic pulse(input logic [3:0] v);
        req = v;
        tick();
        req = 4'd0;
    endtask

    // Holds ack high and waits for the next grant; returns its id.
    task automatic collect_grant(input string name, output logic [1:0] id);
        bit found;
        found = 1'b0;
        id = 2'd0;
        evt_ack = 1'b1;
        for (int i = 0; i < 60 && !found; i++) begin
            if (evt_valid) begin
                id = evt_id;
                found = 1'b1;
            end
            tick();
        end
        evt_ack = 1'b0;
        if (found) $display("grant %s id=%0d", name, id);
        check({name, "_seen"}, 32'(found), 32'd1);
    endtask

    logic [1:0] gid;
    int held;

    initial begin
        // ---- reset with requests asserted ----
        rst = 1'b0; req = 4'hF; lcd_ready_i = 1'b1; evt_ack = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        tick(); tick();
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_timeout", 32'(timeout_o), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        req = 4'd0; evt_ack = 1'b0; rst = 1'b1;
        tick(); tick();
        check("post_rst_pending", 32'(pending), 0);
        $display("txn reset done");

        // ---- single request, ack 3 cycles after valid, cooldown ----
        do_reset();
        lcd_ready_i = 1'b1;
        pulse(4'b0010);
        check("single_pend", 32'(pending), 32'h2);
        check("single_early", 32'(evt_valid), 0);
        tick();
        check("single_valid", 32'(evt_valid), 1);
        check("single_id", 32'(evt_id), 1);
        check("model_pin_single", 32'({m_valid, m_id}), 32'b101);
        tick(); tick();
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        check("single_ack_valid", 32'(evt_valid), 0);
        check("single_ack_pend", 32'(pending), 0);
        pulse(4'b0010);
        for (int i = 0; i < 3; i++) begin
            check("cool_no_valid", 32'(evt_valid), 0);
            tick();
        end
        check("cool_no_valid_last", 32'(evt_valid), 0);
        tick();
        check("cool_regrant", 32'(evt_valid), 1);
        evt_ack = 1'b1; tick(); evt_ack = 1'b0;
        $display("txn single done");

        // ---- round-robin ordering ----
        do_reset();
        lcd_ready_i = 1'b1;
        pulse(4'hF);
        for (int i = 0; i < 4; i++) begin
            collect_grant("rr_all", gid);
            check("rr_order", 32'(gid), 32'(i));
        end
        pulse(4'b0001);
        collect_grant("rr_zero", gid);
        check("rr_zero_id", 32'(gid), 0);
        pulse(4'b1001);
        collect_grant("rr_first", gid);
`ifdef TAMA_ARB_FIXED_PRIO_EN
        check("prio_first", 32'(gid), 0);
`else
        check("rr_first", 32'(gid), 3);
`endif
        collect_grant("rr_second", gid);
`ifdef TAMA_ARB_FIXED_PRIO_EN
        check("prio_second", 32'(gid), 3);
`else
        check("rr_second", 32'(gid), 0);
`endif

        // ---- LCD gating ----
        do_reset();
        lcd_ready_i = 1'b0;
        pulse(4'b0100);
        for (int i = 0; i < 20; i++) begin
            check("lcd_block", 32'(evt_valid), 0);
            tick();
        end
        lcd_ready_i = 1'b1;
        tick();
        check("lcd_valid", 32'(evt_valid), 1);
        check("lcd_id", 32'(evt_id), 2);
        $display("txn lcd gating done");

        // ---- timeout (continues the play grant with no ack) ----
        held = 0;
        while (evt_valid && held < 20) begin
            held++;
            tick();
        end
        check("to_held", 32'(held), 32'(ACK_TIMEOUT));
        check("to_pulse", 32'(timeout_o), 1);
        check("to_pend", 32'(pending[2]), 0);
        tick();
        check("to_pulse_end", 32'(timeout_o), 0);
        pulse(4'b1100);
        collect_grant("to_next", gid);
`ifdef TAMA_ARB_FIXED_PRIO_EN
        check("to_next_id", 32'(gid), 2);
`else
        check("to_next_id", 32'(gid), 3);
`endif
        $display("txn timeout done");

        // ---- drop counting ----
        do_reset();
        lcd_ready_i = 1'b0;
        req = 4'b0010;
        repeat (11) tick();
        check("drop_10", 32'(drop_cnt), 10);
        repeat (290) tick();
        req = 4'd0;
        check("drop_sat", 32'(drop_cnt), 255);
        check("drop_pend", 32'(pending), 32'h2);
        do_reset();
        lcd_ready_i = 1'b0;
        pulse(4'hF);
        pulse(4'hF);
        check("drop_multi", 32'(drop_cnt), 4);
        pulse(4'b0011);
        check("drop_multi2", 32'(drop_cnt), 6);
        $display("txn drops done");

        // ---- request colliding with its own ack ----
        do_reset();
        lcd_ready_i = 1'b1;
        pulse(4'b0100);
        tick();
        check("coll_valid", 32'(evt_valid), 1);
        evt_ack = 1'b1; req = 4'b0100;
        tick();
        evt_ack = 1'b0; req = 4'd0;
        check("coll_valid_low", 32'(evt_valid), 0);
        check("coll_pend", 32'(pending), 32'h4);
        check("coll_drop", 32'(drop_cnt), 0);
        $display("txn collision done");

        // ---- randomized traffic against the model ----
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            if (i == 1200) begin
                rst = 1'b0; tick(); tick(); rst = 1'b1;
            end
            for (int b = 0; b < 4; b++) req[b] = ($urandom_range(0, 9) == 0);
            lcd_ready_i = ($urandom_range(0, 4) != 0);
            evt_ack     = ($urandom_range(0, 2) == 0);
            tick();
        end
        req = 4'd0; evt_ack = 1'b0;
        tick();
        $display("txn random done");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
